conv_window_accumulator: RTL
============================

Name: conv_window_accumulator

Overview:
- Sequential accumulator downstream of the pixel×kernel product stage in the 3x3 convolution datapath.
- Accepts one product per valid/ready handshake and sums TAPS products into one window result.
- Presents the window result to the pixel writer over an output valid/ready handshake.
- Each summation step is performed by a carry-lookahead adder sub-module.

Parameters:
- DATA_W, 12, width of each incoming product (unsigned).
- TAPS, 9, products per window.
- ACC_W, 16, accumulator/result width; must be ≥ DATA_W + clog2(TAPS).
- SHIFT, 4, right-shift applied to the window sum before clamping (used only with PIXEL_CLAMP_EN).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  product valid.
- in_ready  out  1  block can accept a product.
- in_data  in  DATA_W  product value.
- in_last  in  1  producer marks the final tap of a window.
- flush  in  1  synchronous abort of the current window.
- out_valid  out  1  window result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  window result.
- err  out  1  one-cycle pulse on in_last/tap-count mismatch.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, tap_cnt=0, out_valid=0, out_data=0, err=0, in_ready=1.
- The input handshake fires when in_valid && in_ready. The output handshake fires when out_valid && out_ready.
- States:
  - IDLE: in_ready=1, acc=0, tap_cnt=0. On an input handshake: acc<=in_data (zero-extended), tap_cnt<=1, go to ACCUM. If TAPS==1, go straight to DONE instead.
  - ACCUM: in_ready=1. On an input handshake: acc<=acc+in_data via the adder, tap_cnt++. When the accepted tap is number TAPS: latch out_data from the final sum, set out_valid=1 on the next cycle, go to DONE.
  - DONE: in_ready=0, out_valid=1, out_data held stable. On an output handshake: out_valid<=0, acc<=0, tap_cnt<=0, go to IDLE.
- Latency: out_valid rises one cycle after the TAPS-th input handshake. Minimum throughput is one window per TAPS+1 cycles.
- in_last check: on each input handshake, compare in_last with (tap is number TAPS).
  - On mismatch, err pulses high for one cycle, coincident with the cycle after the handshake.
  - The window still closes on tap count only; in_last never terminates a window early.
- flush: when sampled high in any state, the next state is IDLE, acc=0, tap_cnt=0, out_valid=0.
  - A pending result is discarded. An input handshake in the same cycle is dropped.
  - flush has priority over both handshakes.
- in_valid low mid-window: the block holds in ACCUM indefinitely; no timeout.
- out_ready high while out_valid=0: no effect.
- Arithmetic: unsigned, zero-extended to ACC_W. The sum cannot overflow given the ACC_W rule; no wrap handling is needed.
- Asynchronous reset asserted mid-window clears everything immediately; no partial result is emitted.

Optional Feature:
- Macro: PIXEL_CLAMP_EN.
- Defined: out_data = min(sum >> SHIFT, 255), zero-extended to ACC_W. Bits [ACC_W-1:8] are always 0.
- Undefined: out_data = raw sum; SHIFT is unused.
- Timing and handshakes are identical in both builds.

Decomposition:
- Shared package conv_pkg holds:
  - DATA_W/TAPS/ACC_W defaults;
  - the state enum (IDLE, ACCUM, DONE);
  - the PIX_MAX=255 constant.
- One sub-module: acc_cla_adder, a combinational ACC_W-bit carry-lookahead adder with no carry-in and a truncated sum. The accumulator update uses it.
- Tap counter, FSM, and clamp logic live in the top module.

Test Plan:
- Stream of 9 products, each 4095, with in_last on the 9th and out_ready=1 → out_valid one cycle after the 9th handshake. out_data=36855 (clamp off) or 255 (clamp on; 36855>>4=2303→255). err never pulses.
- Products 1..9 with gaps in in_valid, out_ready held 0 for 5 cycles → out_data=45 stable all 5 cycles, in_ready=0 throughout DONE, then IDLE after the handshake. With clamp on: 45>>4=2.
- in_last asserted on the 5th tap → err pulses once. The window still completes at the 9th tap with the correct sum.
- flush asserted after 4 taps, then a fresh window of 9×10 → out_data=90 (clamp off). The first 4 taps do not contribute.
- rst_n pulled low asynchronously after 6 taps → all outputs return to reset values immediately without a clock edge. The next full window sums correctly.
- Back-to-back windows with out_ready=1: the second window's first product is accepted the cycle after the output handshake. Measured period = 10 cycles.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window accumulator:
// parameter defaults, FSM state encoding and the pixel clamp ceiling.
package conv_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int TAPS_DEF   = 9;
  localparam int ACC_W_DEF  = 16;
  localparam int SHIFT_DEF  = 4;

  // Largest value an 8-bit output pixel can carry.
  localparam int PIX_MAX = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_cla_adder.sv
// Combinational carry-lookahead adder (Kogge-Stone parallel prefix).
// No carry-in; the carry-out is discarded, so the sum is truncated to W bits.
module acc_cla_adder
  import conv_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  localparam int STAGES = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0] gen_s  [0:STAGES];
  logic [W-1:0] prop_s [0:STAGES];
  logic [W-1:0] half_sum;

  // Prefix tree: after the last stage gen_s[STAGES][i] is the carry out of bit i.
  always_comb begin
    half_sum  = a ^ b;
    gen_s[0]  = a & b;
    prop_s[0] = a ^ b;
    for (int s = 0; s < STAGES; s++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << s)) begin
          gen_s[s+1][i]  = gen_s[s][i] | (prop_s[s][i] & gen_s[s][i - (1 << s)]);
          prop_s[s+1][i] = prop_s[s][i] & prop_s[s][i - (1 << s)];
        end else begin
          gen_s[s+1][i]  = gen_s[s][i];
          prop_s[s+1][i] = prop_s[s][i];
        end
      end
    end
  end

  // Bit i sums its half-sum with the carry coming out of bit i-1.
  always_comb begin
    sum    = half_sum;
    for (int i = 1; i < W; i++) begin
      sum[i] = half_sum[i] ^ gen_s[STAGES][i-1];
    end
  end

endmodule

// File: rtl/conv_window_accumulator.sv
// Window accumulator: sums TAPS unsigned products per window and hands the
// result to the pixel writer. Optional build macro PIXEL_CLAMP_EN turns the
// result into an 8-bit pixel: min(sum >> SHIFT, 255), zero-extended.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. in_ready depends only on the FSM state (low only in DONE); a
// producer may hold in_valid as long as it likes. out_valid stays high with
// out_data stable until out_ready is seen high. flush overrides both.
module conv_window_accumulator
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              err
);

  localparam int CNT_W = $clog2(TAPS + 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   tap_cnt_q, tap_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               err_q, err_d;

  logic [ACC_W-1:0]   data_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic               in_fire;
  logic               out_fire;
  logic               is_last_tap;

  // Clamp a window sum to an 8-bit pixel after scaling down by SHIFT.
  function automatic logic [ACC_W-1:0] clamp_pixel(input logic [ACC_W-1:0] s);
    logic [ACC_W-1:0] shifted;
    shifted = s >> SHIFT;
    if (shifted > ACC_W'(PIX_MAX)) begin
      return ACC_W'(PIX_MAX);
    end
    return shifted;
  endfunction

  // Result formatting is the only difference between the two builds.
  function automatic logic [ACC_W-1:0] format_result(input logic [ACC_W-1:0] s);
`ifdef PIXEL_CLAMP_EN
    return clamp_pixel(s);
`else
    return s;
`endif
  endfunction

  assign data_ext = ACC_W'(in_data);
  assign in_ready = (state_q != DONE);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  acc_cla_adder #(
    .W(ACC_W)
  ) u_adder (
    .a  (acc_q),
    .b  (data_ext),
    .sum(acc_sum)
  );

  // The tap being accepted is number tap_cnt_q+1 (number 1 while idle).
  always_comb begin
    if (state_q == IDLE) begin
      is_last_tap = (TAPS == 1);
    end else begin
      is_last_tap = (tap_cnt_q == CNT_W'(TAPS - 1));
    end
  end

  // Next-state logic: flush first, then the per-state handshake handling.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tap_cnt_d   = tap_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = 1'b0;
    if (flush) begin
      state_d     = IDLE;
      acc_d       = '0;
      tap_cnt_d   = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            acc_d     = data_ext;
            tap_cnt_d = CNT_W'(1);
            err_d     = (in_last != is_last_tap);
            if (is_last_tap) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              out_data_d  = format_result(data_ext);
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_fire) begin
            acc_d     = acc_sum;
            tap_cnt_d = tap_cnt_q + CNT_W'(1);
            err_d     = (in_last != is_last_tap);
            // in_last never closes a window; only the tap count does.
            if (is_last_tap) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              out_data_d  = format_result(acc_sum);
            end
          end
        end
        DONE: begin
          if (out_fire) begin
            state_d     = IDLE;
            acc_d       = '0;
            tap_cnt_d   = '0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          acc_d       = '0;
          tap_cnt_d   = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tap_cnt_q   <= tap_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule
